// File: rtl/regfile_wb_pkg.sv
// Shared sizes and control levels for the writeback register file.
// Enables are active-high; the reset level is active-low.
package regfile_wb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic RST_ENABLE_N = 1'b0;

endpackage

// File: rtl/regfile_wb_rd_port.sv
// One operand read path: zero/disable gating plus same-cycle WB bypass.
// Combinational, 0-cycle latency; no backpressure.
module regfile_wb_rd_port
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_reg,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (rst != RST_ENABLE_N && raddr != '0 && re == READ_ENABLE) begin
      // Forwarding the in-flight WB write removes the WB->ID hazard.
      if (we == WRITE_ENABLE && waddr == raddr) rdata = wdata;
      else                                      rdata = rdata_reg;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback register file: two bypassed comb read ports, registered debug port, write counter.
// Reads 0-cycle, debug read 1 cycle, writes commit on posedge; no backpressure.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_commit;

  // $0 is never stored, so a discarded write also never counts.
  assign wr_commit = (we == WRITE_ENABLE) && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      wr_count <= '0;
      dbg_data <= '0;
    end else begin
      if (wr_commit) wr_count <= wr_count + 32'd1;
      dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end
  end

  regfile_wb_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .rst       (rst),
    .re        (re1),
    .raddr     (raddr1),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata_reg (regs[raddr1]),
    .rdata     (rdata1)
  );

  regfile_wb_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .rst       (rst),
    .re        (re2),
    .raddr     (raddr2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata_reg (regs[raddr2]),
    .rdata     (rdata2)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: inputs driven on negedge, outputs sampled #1 later.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] wr_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  task automatic test_reset();
    rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'd5;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b0; raddr2 = 5'd0; dbg_addr = 5'd3;
    @(posedge clk); #1;
    tests_run++;
    if (rdata1 !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
    tests_run++;
    if (wr_count !== 32'd0) begin tests_failed++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
    tests_run++;
    if (dbg_data !== 32'd0) begin tests_failed++; $display("FAIL reset_dbg got %h want 0", dbg_data); end
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (dbg_data !== 32'd0) begin tests_failed++; $display("FAIL reset_r3_kept got %h want 0", dbg_data); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; re1 = 1'b0;
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
    #1;
    tests_run++;
    if (rdata1 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_rd_data got %h want deadbeef", rdata1); end
    tests_run++;
    if (wr_count !== 32'd1) begin tests_failed++; $display("FAIL wr_rd_count got %0d want 1", wr_count); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h1234;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd9; dbg_addr = 5'd9;
    #1;
    tests_run++;
    if (rdata1 !== 32'h1234) begin tests_failed++; $display("FAIL bypass_p1 got %h want 1234", rdata1); end
    tests_run++;
    if (rdata2 !== 32'h1234) begin tests_failed++; $display("FAIL bypass_p2 got %h want 1234", rdata2); end
    @(posedge clk); #1;
    tests_run++;
    if (dbg_data !== 32'd0) begin tests_failed++; $display("FAIL bypass_dbg_prewrite got %h want 0", dbg_data); end
    tests_run++;
    if (wr_count !== 32'd2) begin tests_failed++; $display("FAIL bypass_count got %0d want 2", wr_count); end
  endtask

  task automatic test_zero_protect();
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; re1 = 1'b1; raddr1 = 5'd0; dbg_addr = 5'd0;
    #1;
    tests_run++;
    if (rdata1 !== 32'd0) begin tests_failed++; $display("FAIL zero_no_bypass got %h want 0", rdata1); end
    @(negedge clk);
    we = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (dbg_data !== 32'd0) begin tests_failed++; $display("FAIL zero_dbg got %h want 0", dbg_data); end
    tests_run++;
    if (wr_count !== 32'd2) begin tests_failed++; $display("FAIL zero_count got %0d want 2", wr_count); end
  endtask

  task automatic test_read_disable();
    @(negedge clk);
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
    we = 1'b0; waddr = 5'd7; wdata = 32'd1;
    #1;
    tests_run++;
    if (rdata2 !== 32'd0) begin tests_failed++; $display("FAIL rd_disable got %h want 0", rdata2); end
    tests_run++;
    if (rdata1 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL bubble_no_bypass got %h want deadbeef", rdata1); end
    @(negedge clk);
    re2 = 1'b1;
    #1;
    tests_run++;
    if (rdata2 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL bubble_r7 got %h want deadbeef", rdata2); end
    tests_run++;
    if (wr_count !== 32'd2) begin tests_failed++; $display("FAIL bubble_count got %0d want 2", wr_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(i); wdata = 32'hA000_0000 | 32'(i);
      re1 = 1'b1; raddr1 = 5'(i - 1); re2 = 1'b1; raddr2 = 5'(i);
      #1;
      exp = (i == 1) ? 32'd0 : (32'hA000_0000 | 32'(i - 1));
      tests_run++;
      if (rdata1 !== exp) begin tests_failed++; $display("FAIL b2b_prev r%0d got %h want %h", i - 1, rdata1, exp); end
      tests_run++;
      if (rdata2 !== wdata) begin tests_failed++; $display("FAIL b2b_bypass r%0d got %h want %h", i, rdata2, wdata); end
    end
    @(negedge clk);
    we = 1'b0; dbg_addr = 5'd31;
    @(posedge clk); #1;
    tests_run++;
    if (dbg_data !== 32'hA000_001F) begin tests_failed++; $display("FAIL b2b_dbg31 got %h want a000001f", dbg_data); end
    tests_run++;
    if (wr_count !== 32'd33) begin tests_failed++; $display("FAIL b2b_count got %0d want 33", wr_count); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'h5555; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (rdata1 !== 32'd0) begin tests_failed++; $display("FAIL arst_bypass_forced got %h want 0", rdata1); end
    tests_run++;
    if (wr_count !== 32'd0) begin tests_failed++; $display("FAIL arst_count got %0d want 0", wr_count); end
    tests_run++;
    if (dbg_data !== 32'd0) begin tests_failed++; $display("FAIL arst_dbg got %h want 0", dbg_data); end
    // hold reset across an edge: the write to r4 must be lost
    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      raddr1 = 5'(i);
      #1;
      tests_run++;
      if (rdata1 !== 32'd0) begin tests_failed++; $display("FAIL arst_clear r%0d got %h want 0", i, rdata1); end
    end
    @(negedge clk);
    we = 1'b1; waddr = 5'd2; wdata = 32'h2222;
    @(negedge clk);
    we = 1'b0; raddr2 = 5'd2;
    #1;
    tests_run++;
    if (rdata2 !== 32'h2222) begin tests_failed++; $display("FAIL post_rst_write got %h want 2222", rdata2); end
    tests_run++;
    if (wr_count !== 32'd1) begin tests_failed++; $display("FAIL post_rst_count got %0d want 1", wr_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_protect();
    test_read_disable();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
